// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the TDM demultiplexer.
// TDM_DEMUX_PARITY_EN adds the PAR state for the trailing parity slot.
package tdm_demux_pkg;

   localparam int N_SLOTS_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1
`ifdef TDM_DEMUX_PARITY_EN
      ,PAR = 2'd2
`endif
   } state_e;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot index counter for the TDM demultiplexer.
// The controls are prioritised clear > load-1 > increment.
module tdm_slot_cnt #(
   parameter int N_SLOTS = 8,
   parameter int SEL_W   = $clog2(N_SLOTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             ld1_i,
   input  logic             inc_i,
   output logic [SEL_W-1:0] cnt_o
);

   logic [SEL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)      cnt_d = '0;
      else if (ld1_i) cnt_d = SEL_W'(1);
      else if (inc_i) cnt_d = cnt_q + SEL_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM frame collector: gathers one bit per slot and publishes whole frames.
// Define TDM_DEMUX_PARITY_EN for a trailing even-parity slot and the par_err output.
module tdm_demux
   import tdm_demux_pkg::*;
#(
   parameter int N_SLOTS = N_SLOTS_DEF,
   parameter int SEL_W   = $clog2(N_SLOTS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               sync,
   input  logic               din,
   output logic [N_SLOTS-1:0] dout,
   output logic               valid,
   output logic [SEL_W-1:0]   slot,
   output logic               busy,
   output logic               frame_err
`ifdef TDM_DEMUX_PARITY_EN
   ,output logic              par_err
`endif
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(N_SLOTS - 1);

   state_e             state_q;
   logic [N_SLOTS-1:0] shadow_q, dout_q;
   logic               valid_q, ferr_q;
   logic               last, take, ld1, inc, clr;
`ifdef TDM_DEMUX_PARITY_EN
   logic               par_err_q;
`endif

   always_comb begin
      last = (slot == LAST);
      take = en & ~sync;
      ld1  = en & sync;
      inc  = take & (state_q == RUN) & ~last;
`ifdef TDM_DEMUX_PARITY_EN
      // counter parks at the last data slot while the parity bit is awaited
      clr  = take & (state_q == PAR);
`else
      clr  = take & (state_q == RUN) & last;
`endif
   end

   tdm_slot_cnt #(.N_SLOTS(N_SLOTS), .SEL_W(SEL_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .ld1_i (ld1),
      .inc_i (inc),
      .cnt_o (slot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shadow_q  <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         par_err_q <= 1'b0;
`endif
         if (en) begin
            case (state_q)
               IDLE: begin
                  if (sync) begin
                     shadow_q[0] <= din;
                     state_q     <= RUN;
                  end
               end
               default: begin
                  if (sync) begin
                     // resync mid-frame: drop the partial frame and restart at slot 1
                     ferr_q      <= 1'b1;
                     shadow_q[0] <= din;
                     state_q     <= RUN;
                  end else if (state_q == RUN) begin
                     shadow_q[slot] <= din;
`ifdef TDM_DEMUX_PARITY_EN
                     if (last) state_q <= PAR;
`else
                     if (last) begin
                        dout_q  <= {din, shadow_q[N_SLOTS-2:0]};
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                     end
`endif
                  end
`ifdef TDM_DEMUX_PARITY_EN
                  else begin
                     dout_q    <= shadow_q;
                     valid_q   <= 1'b1;
                     par_err_q <= (^shadow_q) ^ din;
                     state_q   <= IDLE;
                  end
`endif
               end
            endcase
         end
      end
   end

   assign dout      = dout_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);
`ifdef TDM_DEMUX_PARITY_EN
   assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed and randomized bench for tdm_demux against a queue-based frame model.
module tb_tdm_demux;

   localparam int N = 8;
   localparam int SW = $clog2(N);
`ifdef TDM_DEMUX_PARITY_EN
   localparam int FL = N + 1;
`else
   localparam int FL = N;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1, en = 1'b0, sync = 1'b0, din = 1'b0;
   logic [N-1:0]  dout;
   logic          valid, busy, frame_err;
   logic [SW-1:0] slot;
`ifdef TDM_DEMUX_PARITY_EN
   logic          par_err;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int vcyc[$];

   bit           mq[$];
   logic [N-1:0] e_dout;
   logic         e_valid, e_ferr, e_par;

   tdm_demux #(.N_SLOTS(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sync      (sync),
      .din       (din),
      .dout      (dout),
      .valid     (valid),
      .slot      (slot),
      .busy      (busy),
      .frame_err (frame_err)
`ifdef TDM_DEMUX_PARITY_EN
      ,.par_err  (par_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Frame-level model: a frame is the bits collected since the last accepted sync.
   task automatic model(input logic r, input logic e, input logic s, input logic d);
      e_valid = 1'b0;
      e_ferr  = 1'b0;
      e_par   = 1'b0;
      if (r) begin
         mq.delete();
         e_dout = '0;
      end else if (e) begin
         if (s) begin
            if (mq.size() > 0) e_ferr = 1'b1;
            mq.delete();
            mq.push_back(d);
         end else if (mq.size() > 0) begin
            mq.push_back(d);
            if (mq.size() == FL) begin
               for (int k = 0; k < N; k++) e_dout[k] = mq[k];
               e_valid = 1'b1;
               e_par   = (^e_dout) ^ mq[FL-1];
               mq.delete();
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic e, input logic s, input logic d);
      int sz;
      @(negedge clk);
      rst = r; en = e; sync = s; din = d;
      @(posedge clk);
      cyc++;
      model(r, e, s, d);
      #1;
      sz = mq.size();
      if (valid === 1'b1) vcyc.push_back(cyc);
      chk("valid", 32'(valid), 32'(e_valid));
      chk("frame_err", 32'(frame_err), 32'(e_ferr));
      chk("dout", 32'(dout), 32'(e_dout));
      chk("busy", 32'(busy), 32'(sz > 0));
      chk("slot", 32'(slot), (sz >= N) ? 32'(N - 1) : 32'(sz));
`ifdef TDM_DEMUX_PARITY_EN
      chk("par_err", 32'(par_err), 32'(e_par));
`endif
   endtask

   task automatic send_frame(input logic [N-1:0] v, input logic pb, input int stall_at, input int stall_len);
      for (int k = 0; k < N; k++) begin
         step(1'b0, 1'b1, (k == 0), v[k]);
         if (k == stall_at)
            for (int j = 0; j < stall_len; j++)
               step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
`ifdef TDM_DEMUX_PARITY_EN
      step(1'b0, 1'b1, 1'b0, pb);
`else
      if (pb === 1'bx) step(1'b0, 1'b0, 1'b0, 1'b0);
`endif
   endtask

   initial begin
      logic [N-1:0] v;
      // reset state
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // basic frame 8'h4D and its single valid pulse
      vcyc.delete();
      send_frame(8'h4D, 1'b0, -1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("4D_valid_count", 32'(vcyc.size()), 32'd1);
      chk("4D_dout", 32'(dout), 32'h4D);

      // stall of 3 cycles after slot 4
      vcyc.delete();
      send_frame(8'h4D, 1'b0, 4, 3);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("stall_valid_count", 32'(vcyc.size()), 32'd1);

      // resync at slot 5 then a full 8'hFF frame
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, (k == 0), 1'b1);
      chk("slot5", 32'(slot), 32'd5);
      send_frame(8'hFF, 1'b0, -1, 0);
      chk("FF_dout", 32'(dout), 32'hFF);

      // back-to-back frames with zero gap
      vcyc.delete();
      send_frame(8'hA5, 1'b0, -1, 0);
      send_frame(8'h3C, 1'b1, -1, 0);
      chk("b2b_count", 32'(vcyc.size()), 32'd2);
      if (vcyc.size() == 2) chk("b2b_gap", 32'(vcyc[1] - vcyc[0]), 32'(FL));
      chk("3C_dout", 32'(dout), 32'h3C);

      // reset mid-frame at slot 3, then a clean frame
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, (k == 0), 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("rst_dout", 32'(dout), 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      send_frame(8'h96, 1'b0, -1, 0);
      chk("post_rst_dout", 32'(dout), 32'h96);

`ifdef TDM_DEMUX_PARITY_EN
      send_frame(8'h4D, 1'b0, -1, 0);
      send_frame(8'h4D, 1'b1, -1, 0);
`endif

      // randomized traffic: idle noise, stalls, resyncs and occasional reset
      for (int f = 0; f < 40; f++) begin
         v = N'($urandom);
         for (int j = 0; j < int'($urandom_range(0, 2)); j++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
         for (int k = 0; k < FL; k++) begin
            step(($urandom_range(0, 99) == 0), 1'b1,
                 (k == 0) || ($urandom_range(0, 24) == 0),
                 (k < N) ? v[k] : 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0)
               step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have parameter N_SLOTS, default 8, the number of data slots per frame (range 2..16).
REQ-002 The block SHALL have parameter SEL_W, default $clog2(N_SLOTS), the slot index width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port en  input  1  slot strobe; din and sync are sampled only when en=1.
REQ-006 The block SHALL have port sync  input  1  frame marker, high together with the slot-0 bit.
REQ-007 The block SHALL have port din  input  1  serial TDM bit stream.
REQ-008 The block SHALL have port dout  output  N_SLOTS  last complete frame; dout[k] holds the slot-k bit.
REQ-009 The block SHALL have port valid  output  1  one-cycle pulse marking a dout update.
REQ-010 The block SHALL have port slot  output  SEL_W  index of the next slot expected.
REQ-011 The block SHALL have port busy  output  1  high while a frame is partially collected.
REQ-012 The block SHALL have port frame_err  output  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and, with the macro only, PAR.
REQ-014 IDLE: on en&sync, shadow[0]<=din, slot<=1, go RUN; en&!sync SHALL be ignored; en=0 SHALL hold.
REQ-015 RUN: on en&!sync, shadow[slot]<=din and slot<=slot+1; en=0 SHALL stall with all state held.
REQ-016 RUN, slot=N_SLOTS-1, en&!sync (no macro): at that edge dout<={din,shadow[N_SLOTS-2:0]}, valid<=1, slot<=0, go IDLE.
REQ-017 valid SHALL be high exactly one cycle, in the cycle after the edge sampling the final bit; latency is 1 cycle.
REQ-018 dout SHALL hold its value between updates and SHALL never show a partial frame.
REQ-019 RUN with en&sync SHALL discard the partial frame, pulse frame_err, restart with shadow[0]<=din, slot<=1, and stay in RUN.
REQ-020 A sync on the cycle right after a completed frame SHALL be accepted, so back-to-back frames have zero gap.
REQ-021 busy SHALL equal (state!=IDLE); slot SHALL be 0 in IDLE.

Reset
REQ-022 On rst=1 at a clock edge: state<=IDLE, slot<=0, dout<=0, valid<=0, frame_err<=0, shadow<=0; par_err<=0 when present.
REQ-023 rst SHALL take priority over en and sync; a frame in progress SHALL be dropped with no valid and no frame_err.

Configuration
REQ-024 Macro TDM_DEMUX_PARITY_EN, when defined, SHALL add output par_err (1 bit) and one extra slot after slot N_SLOTS-1 carrying even parity over the N data bits.
REQ-025 With the macro, RUN at the last data slot SHALL go to PAR; in PAR, en&!sync SHALL update dout, pulse valid, set par_err=(^data ^ din), and go IDLE.
REQ-026 With the macro, en&sync in PAR SHALL behave as REQ-019.
REQ-027 Without the macro, par_err and PAR SHALL not exist, and the frame length SHALL be N_SLOTS.

Structure
REQ-028 Package tdm_demux_pkg SHALL hold the state enum and the default slot-count constant.
REQ-029 The slot counter with increment, clear and load-1 controls SHALL be sub-module tdm_slot_cnt; the FSM, shadow register and output registers SHALL stay in tdm_demux.

Verification
REQ-030 N=8, en=1, sync with slot 0, din=1,0,1,1,0,0,1,0 -> dout=8'h4D and a single valid pulse in the cycle after the 8th bit.
REQ-031 Same frame with en=0 for 3 cycles after slot 4 -> same dout, valid delayed by 3 cycles, slot held at 5 during the stall.
REQ-032 sync reasserted at slot 5, then a full frame of 8'hFF -> frame_err pulse once, then dout=8'hFF with a single valid.
REQ-033 Two frames back-to-back (8'hA5 then 8'h3C) with no gap -> two valid pulses 8 cycles apart with the correct values.
REQ-034 rst asserted at slot 3 -> all outputs 0 next cycle, no valid, no frame_err; the next sync starts a clean frame.
REQ-035 With TDM_DEMUX_PARITY_EN: frame 8'h4D with parity bit 0 -> par_err=0; with parity bit 1 -> par_err=1, each coincident with valid.
